// File: rtl/m_store_buffer.sv
// M-stage store buffer: aligns store data onto memory lanes, queues up to DEPTH
// entries and drains them over valid/ready. Define STORE_MERGE_EN to merge same-word stores into the tail.
module m_store_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic [1:0]                 st_size,
  output logic                       st_exc,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_byteen,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_conflict,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int NB = DATA_W / 8;
  localparam int L  = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(NB - 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [NB-1:0]     be_q   [DEPTH];
  logic [NB-1:0]     be_d   [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [L-1:0]      off;
  logic [NB-1:0]     base_mask, lane_be;
  logic [DATA_W-1:0] shifted, lane_data;
  logic [ADDR_W-1:0] st_waddr, ld_waddr;
  logic [PW-1:0]     idx;
  logic              illegal, full, enq, deq, alloc, merge;

  assign off      = st_addr[L-1:0];
  assign st_waddr = st_addr & ~LO_MASK;
  assign ld_waddr = ld_addr & ~LO_MASK;

  always_comb begin
    base_mask = '0;
    illegal   = 1'b0;
    case (st_size)
      2'b00: base_mask = NB'(1);
      2'b01: begin
        base_mask = NB'(3);
        illegal   = off[0];
      end
      2'b10: begin
        base_mask = NB'(15);
        illegal   = |off[1:0];
      end
      default: begin
        base_mask = '1;
        illegal   = (DATA_W == 32) || (|off);
      end
    endcase
  end

  assign lane_be = base_mask << off;
  assign shifted = st_data << {off, 3'b000};

  // Bytes above the access size in st_data must not leak onto unused lanes.
  always_comb begin
    lane_data = '0;
    for (int b = 0; b < NB; b++) begin
      if (lane_be[b]) lane_data[8*b +: 8] = shifted[8*b +: 8];
    end
  end

  assign full      = (count_q == CW'(DEPTH));
  assign st_ready  = !full;
  assign mem_valid = (count_q != '0);
  assign enq       = st_valid && st_ready && !illegal;
  assign st_exc    = st_valid && st_ready && illegal;
  assign deq       = mem_valid && mem_ready;
  assign alloc     = enq && !merge;

`ifdef STORE_MERGE_EN
  logic [PW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - 1'b1;
  // count >= 2 keeps the head (possibly mid-handshake) out of merging.
  assign merge = enq && (count_q >= CW'(2)) && (addr_q[tail_ptr] == st_waddr);
`else
  assign merge = 1'b0;
`endif

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    be_d     = be_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (alloc) begin
      addr_d[wr_ptr_q] = st_waddr;
      data_d[wr_ptr_q] = lane_data;
      be_d[wr_ptr_q]   = lane_be;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
`ifdef STORE_MERGE_EN
    if (merge) begin
      for (int b = 0; b < NB; b++) begin
        if (lane_be[b]) data_d[tail_ptr][8*b +: 8] = lane_data[8*b +: 8];
      end
      be_d[tail_ptr] = be_q[tail_ptr] | lane_be;
    end
`endif
    if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({alloc, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      be_q     <= be_d;
    end
  end

  // Only entries occupied before the edge count; a store accepted this cycle does not.
  always_comb begin
    ld_conflict = 1'b0;
    idx         = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if ((CW'(k) < count_q) && (addr_q[idx] == ld_waddr)) ld_conflict = 1'b1;
    end
  end

  assign mem_addr   = addr_q[rd_ptr_q];
  assign mem_wdata  = data_q[rd_ptr_q];
  assign mem_byteen = be_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: tb/tb_m_store_buffer.sv
// Directed bench for m_store_buffer: queue-based reference model checked every cycle
// on a 32-bit instance, plus literal expectations on 32- and 64-bit instances.
module tb_m_store_buffer;
  logic        clk;
  logic        reset;
  logic        st_valid, st_ready, st_exc, mem_valid, mem_ready, ld_conflict;
  logic [31:0] st_addr, st_data, mem_addr, mem_wdata, ld_addr;
  logic [1:0]  st_size;
  logic [3:0]  mem_byteen;
  logic [2:0]  count;

  logic        w_st_valid, w_st_ready, w_st_exc, w_mem_valid, w_mem_ready, w_ld_conflict;
  logic [31:0] w_st_addr, w_mem_addr, w_ld_addr;
  logic [63:0] w_st_data, w_mem_wdata;
  logic [1:0]  w_st_size;
  logic [7:0]  w_mem_byteen;
  logic [2:0]  w_count;

  int checks = 0;
  int errors = 0;

`ifdef STORE_MERGE_EN
  localparam logic [2:0]  EXP_MCOUNT = 3'd2;
  localparam logic [3:0]  EXP_MBE    = 4'b0011;
  localparam logic [31:0] EXP_MDATA  = 32'h0000_2211;
`else
  localparam logic [2:0]  EXP_MCOUNT = 3'd3;
  localparam logic [3:0]  EXP_MBE    = 4'b0001;
  localparam logic [31:0] EXP_MDATA  = 32'h0000_0011;
`endif

  m_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_exc(st_exc),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byteen(mem_byteen), .ld_addr(ld_addr),
    .ld_conflict(ld_conflict), .count(count)
  );

  m_store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
    .clk(clk), .reset(reset), .st_valid(w_st_valid), .st_ready(w_st_ready),
    .st_addr(w_st_addr), .st_data(w_st_data), .st_size(w_st_size), .st_exc(w_st_exc),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr),
    .mem_wdata(w_mem_wdata), .mem_byteen(w_mem_byteen), .ld_addr(w_ld_addr),
    .ld_conflict(w_ld_conflict), .count(w_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit illegal_m(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd1) return a[0];
    if (sz == 2'd2) return a[1:0] != 2'b00;
    if (sz == 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic ent_t lanes_m(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    ent_t e;
    int   nbytes;
    int   o;
    nbytes = 1 << sz;
    o      = int'(a % 4);
    e.a    = a & ~32'h3;
    e.be   = 4'(((1 << nbytes) - 1) << o);
    e.d    = '0;
    for (int b = 0; b < 4; b++)
      if (e.be[b]) e.d[8*b +: 8] = d[8*(b-o) +: 8];
    return e;
  endfunction

  function automatic bit conflict_m(input logic [31:0] a);
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].a == (a & ~32'h3)) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: a queue of pending stores updated on each clock edge.
  initial begin
    int   sz;
    bit   enq, deq;
    ent_t e, t;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
      end else begin
        sz  = mq.size();
        enq = st_valid && (sz < 4) && !illegal_m(st_addr, st_size);
        deq = (sz > 0) && mem_ready;
        if (enq) begin
          e = lanes_m(st_addr, st_data, st_size);
`ifdef STORE_MERGE_EN
          if (sz >= 2 && mq[sz-1].a == e.a) begin
            t = mq[sz-1];
            for (int b = 0; b < 4; b++)
              if (e.be[b]) t.d[8*b +: 8] = e.d[8*b +: 8];
            t.be = t.be | e.be;
            mq[sz-1] = t;
          end else begin
            mq.push_back(e);
          end
`else
          mq.push_back(e);
`endif
        end
        if (deq) void'(mq.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("cyc_st_ready", st_ready, mq.size() < 4);
        chk("cyc_count", count, mq.size());
        chk("cyc_mem_valid", mem_valid, mq.size() != 0);
        chk("cyc_st_exc", st_exc, st_valid && (mq.size() < 4) && illegal_m(st_addr, st_size));
        chk("cyc_ld_conflict", ld_conflict, conflict_m(ld_addr));
        if (mq.size() != 0) begin
          chk("cyc_mem_addr", mem_addr, mq[0].a);
          chk("cyc_mem_wdata", mem_wdata, mq[0].d);
          chk("cyc_mem_byteen", mem_byteen, mq[0].be);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    st_size  = sz;
  endtask

  task automatic wput(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    w_st_valid = 1'b1;
    w_st_addr  = a;
    w_st_data  = d;
    w_st_size  = sz;
  endtask

  initial begin
    reset = 1'b0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_size = '0; mem_ready = 1'b0; ld_addr = '0;
    w_st_valid = 1'b0; w_st_addr = '0; w_st_data = '0; w_st_size = '0; w_mem_ready = 1'b1; w_ld_addr = '0;

    neg();
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_byteen", mem_byteen, 0);
    chk("rst_ld_conflict", ld_conflict, 0);
    chk("rst_st_exc", st_exc, 0);
    chk("rst_w_count", w_count, 0);
    step(); reset = 1'b1;

    // byte store to the top lane
    put(32'h1003, 32'h0000_00AB, 2'b00);
    neg(); chk("sb_exc", st_exc, 0);
    step(); st_valid = 1'b0;
    neg();
    chk("sb_mem_valid", mem_valid, 1);
    chk("sb_mem_addr", mem_addr, 32'h1000);
    chk("sb_byteen", mem_byteen, 4'b1000);
    chk("sb_wdata", mem_wdata, 32'hAB00_0000);
    mem_ready = 1'b1; step(); mem_ready = 1'b0;
    neg(); chk("sb_drained", count, 0);

    // misaligned half
    put(32'h2001, 32'h1234, 2'b01);
    neg(); chk("sh_mis_exc", st_exc, 1);
    step(); st_valid = 1'b0;
    neg();
    chk("sh_mis_count", count, 0);
    chk("sh_mis_valid", mem_valid, 0);

    // aligned upper half, upper data bytes must be dropped
    put(32'h2002, 32'h1234_5678, 2'b01);
    step(); st_valid = 1'b0;
    neg();
    chk("sh_byteen", mem_byteen, 4'b1100);
    chk("sh_wdata", mem_wdata, 32'h5678_0000);
    put(32'h2008, 32'h1, 2'b11);
    neg(); chk("sd32_exc", st_exc, 1);
    step(); st_valid = 1'b0;
    mem_ready = 1'b1; step(); mem_ready = 1'b0;

    // fill to full, one-cycle drain, order and wrap
    for (int i = 0; i < 5; i++) begin
      put(32'h100 + 32'(4*i), 32'hA0 + 32'(i), 2'b10);
      if (i < 4) step();
    end
    neg();
    chk("full_st_ready", st_ready, 0);
    chk("full_count", count, 4);
    #1 mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    neg();
    chk("after_deq_count", count, 3);
    chk("after_deq_ready", st_ready, 1);
    chk("after_deq_head", mem_addr, 32'h104);
    chk("after_deq_data", mem_wdata, 32'hA1);
    step(); st_valid = 1'b0;
    neg(); chk("refill_count", count, 4);
    #1 mem_ready = 1'b1;
    step();
    put(32'h120, 32'hC0, 2'b10);
    step(); st_valid = 1'b0;
    neg(); chk("enq_deq_count", count, 3);
    for (int i = 0; i < 5; i++) step();
    neg();
    chk("empty_valid", mem_valid, 0);
    chk("empty_count", count, 0);
    #1 mem_ready = 1'b0;

    // load conflict
    step();
    put(32'h3000, 32'h55, 2'b10);
    step(); st_valid = 1'b0; ld_addr = 32'h3002;
    neg(); chk("ldc_hit", ld_conflict, 1);
    #1 ld_addr = 32'h3004;
    #1 chk("ldc_other_word", ld_conflict, 0);
    ld_addr = 32'h3002; mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    neg(); chk("ldc_after_drain", ld_conflict, 0);

    // tail merge (or plain allocation when merging is disabled)
    step();
    put(32'h4000, 32'hDEAD_BEEF, 2'b10); step();
    put(32'h5000, 32'h11, 2'b00); step();
    put(32'h5001, 32'h22, 2'b00); step(); st_valid = 1'b0;
    neg(); chk("merge_count", count, EXP_MCOUNT);
    #1 mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    neg();
    chk("merge_addr", mem_addr, 32'h5000);
    chk("merge_byteen", mem_byteen, EXP_MBE);
    chk("merge_wdata", mem_wdata, EXP_MDATA);
    #1 mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    mem_ready = 1'b0;

    // reset while draining discards everything immediately
    put(32'h6000, 32'h1, 2'b10); step();
    put(32'h6004, 32'h2, 2'b10); step(); st_valid = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
    #1;
    chk("midrst_valid", mem_valid, 0);
    chk("midrst_count", count, 0);
    chk("midrst_ready", st_ready, 1);
    chk("midrst_addr", mem_addr, 0);
    step(); reset = 1'b1; mem_ready = 1'b0;
    neg(); chk("postrst_valid", mem_valid, 0);

    // 64-bit instance
    step();
    wput(32'h18, 64'h1122_3344_5566_7788, 2'b11);
    neg(); chk("w_sd_exc", w_st_exc, 0);
    step();
    wput(32'h1C, 64'hAABB_CCDD, 2'b10);
    neg();
    chk("w_sd_valid", w_mem_valid, 1);
    chk("w_sd_addr", w_mem_addr, 32'h18);
    chk("w_sd_byteen", w_mem_byteen, 8'hFF);
    chk("w_sd_wdata", w_mem_wdata, 64'h1122_3344_5566_7788);
    step(); w_st_valid = 1'b0;
    neg();
    chk("w_sw_addr", w_mem_addr, 32'h18);
    chk("w_sw_byteen", w_mem_byteen, 8'hF0);
    chk("w_sw_wdata", w_mem_wdata, 64'hAABB_CCDD_0000_0000);
    step();
    wput(32'h1C, 64'h1, 2'b11);
    neg(); chk("w_sd_mis_exc", w_st_exc, 1);
    step(); w_st_valid = 1'b0;
    step();
    neg(); chk("w_final_count", w_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
